tx_interp_filter: RTL and testbench
===================================

TX_INTERP_FILTER -- requirements
Module: tx_interp_filter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): input sample buffer depth.
REQ-002 SHALL have parameter INTERP_LOG2, default 3: the interpolation factor is 2^INTERP_LOG2 (8, so 25 Msps in and 200 Msps out).
REQ-003 SHALL have port logic_clk_in, input, 1: 200 MHz logic clock, the only clock.
REQ-004 SHALL have port logic_rst_in, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port data_fir_in, input, 32: [31:16] I and [15:0] Q, both signed 16-bit.
REQ-006 SHALL have port data_fir_valid_in, input, 1: input sample valid.
REQ-007 SHALL have port data_fir_ready_out, output, 1: buffer can accept a sample.
REQ-008 SHALL have port data_fir_out, output, 32: interpolated I/Q at 200 Msps, same packing as input.
REQ-009 SHALL have port fir_rdy_out, output, 1: data_fir_out valid.
REQ-010 SHALL have port underflow_out, output, 1: one-cycle pulse on buffer starvation.
REQ-011 SHALL have port fifo_level_out, output, $clog2(FIFO_DEPTH)+1: current buffer occupancy.
REQ-012 SHALL have port debug_signal, output, 200: [1:0] state, [4:2] phase, [9:5] level, [10] underflow; all other bits are 0.

Function
REQ-013 SHALL accept a sample only on a cycle where data_fir_valid_in and data_fir_ready_out are both 1; data_fir_ready_out = (level < FIFO_DEPTH).
REQ-014 SHALL leave the level unchanged on a simultaneous push and pop, and SHALL NOT overwrite data when the buffer is full.
REQ-015 SHALL implement states IDLE, LOAD, RUN.
- IDLE -> LOAD when level >= 2, popping one sample into prev.
- LOAD -> RUN after one cycle, popping one sample into cur, with phase = 0.
REQ-016 In RUN, phase SHALL increment by 1 every cycle and wrap 7 -> 0.
- At phase 7 with level > 0: pop, prev <= cur, cur <= popped sample, stay in RUN.
- At phase 7 with level = 0: go to IDLE and pulse underflow_out for one cycle.
REQ-017 Per component, the output SHALL be (prev*8 + (cur - prev)*phase) >>> 3, using a 20-bit signed intermediate and arithmetic (floor) shift, truncated to 16 bits.
REQ-018 The output SHALL be registered: data_fir_out/fir_rdy_out at cycle t reflect the state and phase of cycle t-1, giving fir_rdy_out = 1 for exactly 8 cycles per consumed pair step.
REQ-019 When fir_rdy_out = 0, data_fir_out SHALL be 0.
REQ-020 A push arriving in the same cycle as the IDLE->LOAD or phase-7 pop SHALL be counted with no loss.

Reset
REQ-021 While logic_rst_in = 0, and immediately on its assertion, the block SHALL hold: state IDLE, phase 0, prev/cur 0, level 0, data_fir_out 0, fir_rdy_out 0, underflow_out 0, data_fir_ready_out 0.
REQ-022 data_fir_ready_out SHALL be 1 from the first clock edge after reset deasserts.
REQ-023 Reset asserted mid-RUN SHALL discard all buffered samples; no output pulse SHALL follow the reset release.

Structure
REQ-024 Package tx_filter_pkg SHALL hold the state enum, the I/Q width (16), INTERP_LOG2, and the I/Q pack/unpack constants.
REQ-025 The buffer SHALL be sub-module tx_sample_fifo (registered, first-word-fall-through, level output); the interpolator and FSM SHALL live in tx_interp_filter.

Verification
REQ-026 Ramp: push I = 0x0000, then 0x0800, with Q = 0 -> I outputs 0x0000, 0x0100, ..., 0x0700, then underflow_out pulses once.
REQ-027 Negative: push I = 0x0000, then 0xFFF8 -> I outputs 0, -1, -2, ..., -7 (0xFFFF..0xFFF9).
REQ-028 Backpressure: hold valid with 10 queued samples -> ready drops when level = 4, then one sample is accepted per 8 cycles, and fir_rdy_out is continuous with no underflow.
REQ-029 Starvation and restart: push 2 samples, wait 20 cycles, push 2 more -> exactly two 8-cycle valid bursts, two underflow pulses, and data_fir_out = 0 between the bursts.
REQ-030 Reset at phase 3 of RUN -> all outputs reach their reset values asynchronously, level = 0, and no fir_rdy_out after release until 2 new samples are pushed.

Source files
------------

// File: rtl/tx_filter_pkg.sv
// -----------------------------------------------------------------------------
// tx_filter_pkg
// Shared definitions for the TX interpolation filter:
//   - IQ_W / SAMPLE_W : component and packed sample widths
//   - INTERP_LOG2     : default log2 of the interpolation factor
//   - I_LSB / Q_LSB   : bit positions of I ([31:16]) and Q ([15:0])
//   - state_e         : interpolator FSM states
//   - get_i/get_q/pack_iq : sample pack/unpack helpers
// -----------------------------------------------------------------------------
package tx_filter_pkg;

    localparam int unsigned IQ_W        = 16;
    localparam int unsigned SAMPLE_W    = 2 * IQ_W;
    localparam int unsigned INTERP_LOG2 = 3;
    localparam int unsigned I_LSB       = IQ_W;
    localparam int unsigned Q_LSB       = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    function automatic logic [IQ_W-1:0] get_i(input logic [SAMPLE_W-1:0] s);
        return s[I_LSB +: IQ_W];
    endfunction

    function automatic logic [IQ_W-1:0] get_q(input logic [SAMPLE_W-1:0] s);
        return s[Q_LSB +: IQ_W];
    endfunction

    function automatic logic [SAMPLE_W-1:0] pack_iq(input logic [IQ_W-1:0] i,
                                                     input logic [IQ_W-1:0] q);
        return {i, q};
    endfunction

endpackage

// File: rtl/tx_sample_fifo.sv
// -----------------------------------------------------------------------------
// tx_sample_fifo
// Registered first-word-fall-through sample buffer with occupancy output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : write request (accepted only when o_ready is 1)
//   i_data     : write data
//   i_pop      : read request (ignored when empty)
//   o_data     : head-of-buffer data (valid when o_level > 0)
//   o_ready    : buffer can accept a sample
//   o_level    : current occupancy
// -----------------------------------------------------------------------------
module tx_sample_fifo
    import tx_filter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_ready,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_armed;
    logic             w_push;
    logic             w_pop;

    // Ready stays low until the first clock edge after reset release.
    assign o_ready = r_armed && (r_level < LVL_W'(DEPTH));
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && (r_level != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/tx_interp_filter.sv
// -----------------------------------------------------------------------------
// tx_interp_filter
// Linear-interpolating upsampler: each consecutive sample pair (prev, cur)
// produces 2^INTERP_LOG2 output samples prev + (cur - prev) * phase / 2^L.
// Ports:
//   logic_clk_in       : logic clock (output sample rate)
//   logic_rst_in       : asynchronous active-low reset
//   data_fir_in        : input sample, [31:16] I, [15:0] Q, signed
//   data_fir_valid_in  : input sample valid
//   data_fir_ready_out : buffer can accept a sample
//   data_fir_out       : interpolated sample, same packing (0 when not valid)
//   fir_rdy_out        : data_fir_out valid
//   underflow_out      : one-cycle pulse when the buffer starves mid-stream
//   fifo_level_out     : buffer occupancy
//   debug_signal       : [1:0] state, [4:2] phase, [9:5] level, [10] underflow
// -----------------------------------------------------------------------------
module tx_interp_filter #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned INTERP_LOG2 = tx_filter_pkg::INTERP_LOG2
) (
    input  logic                          logic_clk_in,
    input  logic                          logic_rst_in,
    input  logic [31:0]                   data_fir_in,
    input  logic                          data_fir_valid_in,
    output logic                          data_fir_ready_out,
    output logic [31:0]                   data_fir_out,
    output logic                          fir_rdy_out,
    output logic                          underflow_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic [199:0]                  debug_signal
);
    import tx_filter_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ACC_W = IQ_W + INTERP_LOG2 + 1;
    localparam logic [INTERP_LOG2-1:0] LAST_PHASE = '1;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [INTERP_LOG2-1:0]  r_phase;
    logic [INTERP_LOG2-1:0]  w_phase_nxt;
    logic [SAMPLE_W-1:0]     r_prev;
    logic [SAMPLE_W-1:0]     r_cur;
    logic [SAMPLE_W-1:0]     r_data_out;
    logic                    r_fir_rdy;
    logic                    r_underflow;

    logic [SAMPLE_W-1:0]     w_fifo_data;
    logic [LVL_W-1:0]        w_level;
    logic                    w_ready;
    logic                    w_pop;
    logic                    w_load_prev;
    logic                    w_load_cur;
    logic                    w_advance;
    logic                    w_underflow;
    logic [SAMPLE_W-1:0]     w_interp;

    tx_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (logic_clk_in),
        .rst_n   (logic_rst_in),
        .i_valid (data_fir_valid_in),
        .i_data  (data_fir_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_ready (w_ready),
        .o_level (w_level)
    );

    // Sign-extend to ACC_W, form prev*2^L + (cur-prev)*phase, floor-shift back.
    function automatic logic [IQ_W-1:0] interp_comp(input logic [IQ_W-1:0]        p,
                                                    input logic [IQ_W-1:0]        c,
                                                    input logic [INTERP_LOG2-1:0] ph);
        logic signed [ACC_W-1:0] p_ext;
        logic signed [ACC_W-1:0] c_ext;
        logic signed [ACC_W-1:0] acc;
        p_ext = ACC_W'($signed(p));
        c_ext = ACC_W'($signed(c));
        acc   = (p_ext <<< INTERP_LOG2) + (c_ext - p_ext) * $signed(ACC_W'(ph));
        return IQ_W'(acc >>> INTERP_LOG2);
    endfunction

    assign w_interp = pack_iq(interp_comp(get_i(r_prev), get_i(r_cur), r_phase),
                              interp_comp(get_q(r_prev), get_q(r_cur), r_phase));

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_pop       = 1'b0;
        w_load_prev = 1'b0;
        w_load_cur  = 1'b0;
        w_advance   = 1'b0;
        w_underflow = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                if (w_level >= LVL_W'(2)) begin
                    w_pop       = 1'b1;
                    w_load_prev = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Level was >= 2 when entering LOAD, so a second sample is present.
                w_pop       = 1'b1;
                w_load_cur  = 1'b1;
                w_phase_nxt = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_phase_nxt = r_phase + INTERP_LOG2'(1);
                if (r_phase == LAST_PHASE) begin
                    if (w_level != '0) begin
                        w_pop     = 1'b1;
                        w_advance = 1'b1;
                    end else begin
                        w_underflow = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_phase_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_prev      <= '0;
            r_cur       <= '0;
            r_data_out  <= '0;
            r_fir_rdy   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            if (w_load_prev) begin
                r_prev <= w_fifo_data;
            end
            if (w_load_cur) begin
                r_cur <= w_fifo_data;
            end
            if (w_advance) begin
                r_prev <= r_cur;
                r_cur  <= w_fifo_data;
            end
            // Outputs carry the interpolation of the state/phase just left.
            r_fir_rdy   <= (r_state == ST_RUN);
            r_data_out  <= (r_state == ST_RUN) ? w_interp : '0;
            r_underflow <= w_underflow;
        end
    end

    assign data_fir_ready_out = w_ready;
    assign data_fir_out       = r_data_out;
    assign fir_rdy_out        = r_fir_rdy;
    assign underflow_out      = r_underflow;
    assign fifo_level_out     = w_level;

    always_comb begin
        debug_signal       = '0;
        debug_signal[1:0]  = r_state;
        debug_signal[4:2]  = 3'(r_phase);
        debug_signal[9:5]  = 5'(w_level);
        debug_signal[10]   = r_underflow;
    end

endmodule

// File: tb/tb_tx_interp_filter.sv
`timescale 1ns/100ps
module tb_tx_interp_filter;

    localparam int DEPTH = 4;
    localparam int NPH   = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  din   = '0;
    logic         vld   = 1'b0;
    logic         rdy_in;
    logic [31:0]  dout;
    logic         fir_rdy;
    logic         uf;
    logic [2:0]   level;
    logic [199:0] dbg;

    int n_err = 0;
    int n_chk = 0;

    tx_interp_filter #(
        .FIFO_DEPTH  (DEPTH),
        .INTERP_LOG2 (3)
    ) dut (
        .logic_clk_in       (clk),
        .logic_rst_in       (rst_n),
        .data_fir_in        (din),
        .data_fir_valid_in  (vld),
        .data_fir_ready_out (rdy_in),
        .data_fir_out       (dout),
        .fir_rdy_out        (fir_rdy),
        .underflow_out      (uf),
        .fifo_level_out     (level),
        .debug_signal       (dbg)
    );

    always #2.5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sample queue plus "which pair, which fraction" bookkeeping; outputs are
    // computed as plain integer linear interpolation with floor division.
    logic [31:0] mq[$];
    bit          m_loading = 0;
    bit          m_running = 0;
    int          m_step    = 0;
    logic [31:0] m_prev    = '0;
    logic [31:0] m_cur     = '0;
    bit          m_armed   = 0;
    logic [31:0] e_data    = '0;
    bit          e_rdy     = 0;
    bit          e_uf      = 0;

    function automatic logic [15:0] m_comp(input logic [15:0] p, input logic [15:0] c, input int ph);
        int pi, ci, v;
        pi = $signed(p);
        ci = $signed(c);
        v  = pi * NPH + (ci - pi) * ph;
        v  = v >>> 3;
        return v[15:0];
    endfunction

    function automatic logic [31:0] m_out(input logic [31:0] p, input logic [31:0] c, input int ph);
        return {m_comp(p[31:16], c[31:16], ph), m_comp(p[15:0], c[15:0], ph)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_loading = 0; m_running = 0; m_step = 0;
            m_prev = '0; m_cur = '0; m_armed = 0;
            e_data = '0; e_rdy = 0; e_uf = 0;
        end else begin
            bit acc;
            acc   = vld && m_armed && (mq.size() < DEPTH);
            e_rdy = m_running;
            e_data = m_running ? m_out(m_prev, m_cur, m_step) : 32'h0;
            e_uf  = m_running && (m_step == NPH - 1) && (mq.size() == 0);
            if (m_running) begin
                if (m_step == NPH - 1) begin
                    if (mq.size() > 0) begin
                        m_prev = m_cur;
                        m_cur  = mq.pop_front();
                        m_step = 0;
                    end else begin
                        m_running = 0;
                        m_step = 0;
                    end
                end else begin
                    m_step++;
                end
            end else if (m_loading) begin
                m_cur = mq.pop_front();
                m_loading = 0;
                m_running = 1;
                m_step = 0;
            end else if (mq.size() >= 2) begin
                m_prev = mq.pop_front();
                m_loading = 1;
            end
            if (acc) mq.push_back(din);
            m_armed = 1;
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [31:0] cap[$];
    int  bursts = 0, uf_cnt = 0, rdy_cycles = 0, nz_idle = 0;
    bit  saw_stall = 0;
    bit  prev_rdy = 0;

    always @(negedge clk) begin
        chk("data",     dout,             e_data);
        chk("fir_rdy",  32'(fir_rdy),     32'(e_rdy));
        chk("underflow",32'(uf),          32'(e_uf));
        chk("ready",    32'(rdy_in),      32'(m_armed && (mq.size() < DEPTH)));
        chk("level",    32'(level),       32'(mq.size()));
        chk("dbg_phase",32'(dbg[4:2]),    32'(m_step));
        chk("dbg_level",32'(dbg[9:5]),    32'(mq.size()));
        chk("dbg_uf",   32'(dbg[10]),     32'(e_uf));
        chk("dbg_zero", 32'(|dbg[199:11]), 32'h0);
        if (fir_rdy) begin
            cap.push_back(dout);
            rdy_cycles++;
            if (!prev_rdy) bursts++;
        end else if (dout != 0) begin
            nz_idle++;
        end
        if (uf) uf_cnt++;
        if (!rdy_in && level == 3'(DEPTH)) saw_stall = 1;
        prev_rdy = fir_rdy;
    end

    // ---------------- stimulus ----------------
    logic [31:0] stim[$];

    task automatic clr();
        cap.delete();
        bursts = 0; uf_cnt = 0; rdy_cycles = 0; nz_idle = 0; saw_stall = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends every queued sample with valid held high; each wait is bounded.
    task automatic send_all();
        bit ok;
        vld = 1'b1;
        while (stim.size() > 0) begin
            din = stim.pop_front();
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                ok = rdy_in;
                @(posedge clk);
                #1;
            end
            if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        end
        vld = 1'b0;
        din = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // reset state
        wait_cyc(3);
        chk("rst_ready", 32'(rdy_in), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_data",  dout, 32'h0);
        chk("rst_rdy",   32'(fir_rdy), 32'h0);
        rst_n = 1'b1;
        #0.5;
        chk("ready_before_edge", 32'(rdy_in), 32'h0);
        wait_cyc(1);
        chk("ready_after_edge", 32'(rdy_in), 32'h1);

        // ramp
        clr();
        stim.push_back(32'h0000_0000);
        stim.push_back(32'h0800_0000);
        send_all();
        wait_cyc(14);
        chk("ramp_count", 32'(cap.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            w = (k < cap.size()) ? cap[k] : 32'hDEAD_BEEF;
            chk("ramp_i", 32'(w[31:16]), 32'(k * 256));
            chk("ramp_q", 32'(w[15:0]), 32'h0);
        end
        chk("ramp_uf", 32'(uf_cnt), 32'd1);

        // negative slope
        clr();
        stim.push_back(32'h0000_0000);
        stim.push_back(32'hFFF8_0000);
        send_all();
        wait_cyc(14);
        chk("neg_count", 32'(cap.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            logic [15:0] e;
            w = (k < cap.size()) ? cap[k] : 32'hDEAD_BEEF;
            e = 16'(-k);
            chk("neg_i", 32'(w[31:16]), 32'(e));
        end
        chk("neg_i7_literal", (cap.size() == 8) ? 32'(cap[7][31:16]) : 32'h0, 32'h0000_FFF9);

        // backpressure: 10 samples, valid held
        clr();
        for (int k = 0; k < 10; k++) stim.push_back({16'(k * 256), 16'(-(k * 16))});
        send_all();
        wait_cyc(80);
        chk("bp_stall_seen", 32'(saw_stall), 32'h1);
        chk("bp_bursts", 32'(bursts), 32'd1);
        chk("bp_rdy_cycles", 32'(rdy_cycles), 32'd72);
        chk("bp_uf", 32'(uf_cnt), 32'd1);

        // starvation and restart
        clr();
        stim.push_back(32'h0100_0100);
        stim.push_back(32'h0200_FF00);
        send_all();
        wait_cyc(20);
        stim.push_back(32'h7FFF_8000);
        stim.push_back(32'h8000_7FFF);
        send_all();
        wait_cyc(20);
        chk("st_bursts", 32'(bursts), 32'd2);
        chk("st_uf", 32'(uf_cnt), 32'd2);
        chk("st_rdy_cycles", 32'(rdy_cycles), 32'd16);
        chk("st_zero_between", 32'(nz_idle), 32'h0);

        // reset during RUN at phase 3
        clr();
        for (int k = 0; k < 4; k++) stim.push_back({16'(k * 512), 16'(k)});
        send_all();
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            found = (dbg[4:2] == 3'd3);
        end
        chk("reach_phase3", 32'(found), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data",  dout, 32'h0);
        chk("arst_rdy",   32'(fir_rdy), 32'h0);
        chk("arst_uf",    32'(uf), 32'h0);
        chk("arst_ready", 32'(rdy_in), 32'h0);
        chk("arst_level", 32'(level), 32'h0);
        chk("arst_dbg",   32'(|dbg), 32'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        clr();
        wait_cyc(20);
        chk("post_rst_no_out", 32'(rdy_cycles), 32'h0);
        chk("post_rst_ready", 32'(rdy_in), 32'h1);
        stim.push_back(32'h0010_0020);
        stim.push_back(32'h0090_FFA0);
        send_all();
        wait_cyc(14);
        chk("post_rst_burst", 32'(rdy_cycles), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
